// File: rtl/koala_p_round.sv
// One Koala-P round (theta, pi, chi, iota) over a cyclic 257-bit state.
// Define KOALA_P_ROUND_REG_EN to register round_o/valid_o (latency 1); otherwise the round is purely combinational.
module koala_p_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic [256:0] round_i,
    output logic         valid_o,
    output logic [256:0] round_o
);

    localparam int N      = 257;
    localparam int PI_MUL = 121;

    logic [N-1:0] theta_w;
    logic [N-1:0] pi_w;
    logic [N-1:0] chi_w;
    logic [N-1:0] iota_w;

    // All index arithmetic is resolved at elaboration, so every step is plain wiring plus gates.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_theta
            assign theta_w[gi] = round_i[gi]
                               ^ round_i[(gi + 3) % N]
                               ^ round_i[(gi + 10) % N];
        end

        for (genvar gi = 0; gi < N; gi++) begin : g_pi
            assign pi_w[gi] = theta_w[(PI_MUL * gi) % N];
        end

        for (genvar gi = 0; gi < N; gi++) begin : g_chi
            assign chi_w[gi] = pi_w[gi]
                             ^ (~pi_w[(gi + 1) % N] & pi_w[(gi + 2) % N]);
        end
    endgenerate

    assign iota_w = {chi_w[N-1:1], ~chi_w[0]};

`ifdef KOALA_P_ROUND_REG_EN
    logic [N-1:0] round_q;
    logic [N-1:0] round_d;
    logic         valid_q;
    logic         valid_d;

    // Data register only loads on a qualified state; valid tracks valid_i every cycle.
    always_comb begin
        round_d = round_q;
        valid_d = valid_i;
        if (valid_i) begin
            round_d = iota_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    assign round_o = round_q;
    assign valid_o = valid_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign round_o = iota_w;
    assign valid_o = valid_i;
`endif

endmodule

// File: tb/tb_koala_p_round.sv
// Self-checking bench for koala_p_round: hand vectors, reference-model vectors, inverse-round recovery,
// and (when KOALA_P_ROUND_REG_EN is defined) pipeline, hold and reset sequences.
module tb_koala_p_round;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_i;
    logic [256:0] round_i;
    logic         valid_o;
    logic [256:0] round_o;

    int checks = 0;
    int errors = 0;

    logic [256:0] theta_inv [257];
    logic         theta_ok;

    koala_p_round dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .round_i (round_i),
        .valid_o (valid_o),
        .round_o (round_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [256:0] state;
        logic [256:0] expect_o;
    } vec_t;

    vec_t tbl [4];

    task automatic check_vec(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    // Reference forward round written straight from the round definition.
    function automatic logic [256:0] model_round(input logic [256:0] a);
        logic [256:0] b, c, d;
        for (int i = 0; i < 257; i++) b[i] = a[i] ^ a[(i + 3) % 257] ^ a[(i + 10) % 257];
        for (int i = 0; i < 257; i++) c[i] = b[(121 * i) % 257];
        for (int i = 0; i < 257; i++) d[i] = c[i] ^ (~c[(i + 1) % 257] & c[(i + 2) % 257]);
        d[0] = ~d[0];
        return d;
    endfunction

    // theta is a circulant linear map; invert it once by Gauss-Jordan elimination.
    task automatic build_theta_inv();
        logic [256:0] m [257];
        logic [256:0] tmp;
        theta_ok = 1'b1;
        for (int i = 0; i < 257; i++) begin
            m[i] = '0;
            m[i][i] = 1'b1;
            m[i][(i + 3) % 257] = 1'b1;
            m[i][(i + 10) % 257] = 1'b1;
            theta_inv[i] = '0;
            theta_inv[i][i] = 1'b1;
        end
        for (int col = 0; col < 257; col++) begin
            int p;
            p = -1;
            for (int r = col; r < 257; r++) if (p < 0 && m[r][col]) p = r;
            if (p < 0) begin
                theta_ok = 1'b0;
            end else begin
                tmp = m[p]; m[p] = m[col]; m[col] = tmp;
                tmp = theta_inv[p]; theta_inv[p] = theta_inv[col]; theta_inv[col] = tmp;
                for (int r = 0; r < 257; r++) begin
                    if (r != col && m[r][col]) begin
                        m[r] = m[r] ^ m[col];
                        theta_inv[r] = theta_inv[r] ^ theta_inv[col];
                    end
                end
            end
        end
    endtask

    // Inverse round: undo iota, solve chi downward from a guessed top pair, undo pi, undo theta.
    function automatic logic [256:0] inv_round(input logic [256:0] y);
        logic [256:0] d, c, cand, b, a;
        logic [1:0]   gg;
        logic         found;
        d = y;
        d[0] = ~d[0];
        c = '0;
        found = 1'b0;
        for (int g = 0; g < 4; g++) begin
            gg = 2'(g);
            cand = '0;
            cand[256] = gg[1];
            cand[255] = gg[0];
            for (int i = 254; i >= 0; i--) cand[i] = d[i] ^ (~cand[i + 1] & cand[i + 2]);
            if (!found
                && d[255] == (cand[255] ^ (~cand[256] & cand[0]))
                && d[256] == (cand[256] ^ (~cand[0] & cand[1]))) begin
                c = cand;
                found = 1'b1;
            end
        end
        for (int j = 0; j < 257; j++) b[j] = c[(17 * j) % 257];
        for (int i = 0; i < 257; i++) a[i] = ^(theta_inv[i] & b);
        return a;
    endfunction

    function automatic logic [256:0] rand_state();
        logic [287:0] r;
        for (int k = 0; k < 9; k++) r[k * 32 +: 32] = $urandom;
        return r[256:0];
    endfunction

    // Drive one state and sample after the result is due (combinational or one edge later).
    task automatic drive(input logic v, input logic [256:0] s);
        @(negedge clk);
        valid_i = v;
        round_i = s;
`ifdef KOALA_P_ROUND_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [256:0] tmp;
        logic [256:0] s;
        logic [256:0] v [3];
        logic [256:0] prev;

        rst     = 1'b1;
        valid_i = 1'b0;
        round_i = '0;

        tmp = '0;
        tbl[0] = '{"zero", '0, 257'h1};
        tmp = '0; tmp[85] = 1; tmp[87] = 1; tmp[204] = 1; tmp[206] = 1; tmp[255] = 1;
        tbl[1] = '{"bit0", 257'h1, tmp};
        tmp = '1; tmp[0] = 1'b0;
        s = '1;
        tbl[2] = '{"ones", s, tmp};
        tmp = '0; tmp[0] = 1; tmp[68] = 1; tmp[70] = 1; tmp[187] = 1; tmp[189] = 1; tmp[238] = 1; tmp[240] = 1;
        s = '0; s[256] = 1'b1;
        tbl[3] = '{"bit256", s, tmp};

        build_theta_inv();
        check_bit("theta_invertible", theta_ok, 1'b1);

        repeat (2) @(posedge clk);
        #1;
`ifdef KOALA_P_ROUND_REG_EN
        check_vec("reset_round_o", round_o, '0);
`else
        check_vec("reset_round_o", round_o, 257'h1);
`endif
        check_bit("reset_valid_o", valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            drive(1'b1, tbl[k].state);
            check_vec({"vec_", tbl[k].name}, round_o, tbl[k].expect_o);
            check_bit({"vec_valid_", tbl[k].name}, valid_o, 1'b1);
            check_vec({"inv_", tbl[k].name}, inv_round(round_o), tbl[k].state);
        end

        for (int k = 0; k < 100; k++) begin
            s = rand_state();
            drive(1'b1, s);
            check_vec($sformatf("rand_%0d", k), round_o, model_round(s));
            if (k % 10 == 0) check_vec($sformatf("rand_inv_%0d", k), inv_round(round_o), s);
        end

`ifdef KOALA_P_ROUND_REG_EN
        // Back-to-back stream: each result lands exactly one edge after its input.
        for (int k = 0; k < 3; k++) v[k] = rand_state();
        prev = round_o;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            valid_i = 1'b1;
            round_i = v[k];
            #1;
            check_vec($sformatf("stream_pre_%0d", k), round_o, prev);
            @(posedge clk);
            #1;
            check_vec($sformatf("stream_%0d", k), round_o, model_round(v[k]));
            check_bit($sformatf("stream_valid_%0d", k), valid_o, 1'b1);
            prev = round_o;
        end
        drive(1'b0, rand_state());
        check_vec("hold_round_o", round_o, model_round(v[2]));
        check_bit("hold_valid_o", valid_o, 1'b0);

        // Reset in the middle of a valid stream discards the in-flight state.
        drive(1'b1, v[0]);
        check_vec("pre_rst", round_o, model_round(v[0]));
        @(negedge clk);
        rst = 1'b1;
        valid_i = 1'b1;
        round_i = v[1];
        @(posedge clk);
        #1;
        check_vec("rst_round_o", round_o, '0);
        check_bit("rst_valid_o", valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        round_i = v[2];
        #1;
        check_vec("post_rst_pre", round_o, '0);
        @(posedge clk);
        #1;
        check_vec("post_rst_round_o", round_o, model_round(v[2]));
        check_bit("post_rst_valid_o", valid_o, 1'b1);
`else
        // Data is processed even when not qualified; valid simply follows.
        s = rand_state();
        drive(1'b0, s);
        check_vec("unqualified_round_o", round_o, model_round(s));
        check_bit("unqualified_valid_o", valid_o, 1'b0);
        drive(1'b1, s);
        check_bit("requalified_valid_o", valid_o, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
